// File: rtl/pe_mac_pkg.sv
// Shared types and helpers for the pipelined PE multiply-accumulate unit.
package pe_mac_pkg;

  // Widest accumulator the convert helper can handle.
  localparam int unsigned MAC_MAX_W = 64;

  // Output conversion mode.
  typedef enum logic {
    MAC_WRAP = 1'b0,
    MAC_SAT  = 1'b1
  } sat_mode_e;

  // Control token that travels alongside each product.
  typedef struct packed {
    logic valid;
    logic first;
    logic last;
  } stage_tok_t;

  // Result of narrowing the accumulator to the output width.
  typedef struct packed {
    logic [MAC_MAX_W-1:0] val;
    logic                 clamped;
  } conv_res_t;

  // Narrow a sign-extended accumulator to dout_w bits. Wrap mode passes the
  // value through (caller keeps the low bits); saturate mode clamps to the
  // signed dout_w range and reports whether it clamped.
  function automatic conv_res_t mac_convert(
    input logic signed [MAC_MAX_W-1:0] acc,
    input int unsigned                 dout_w,
    input sat_mode_e                   mode
  );
    logic signed [MAC_MAX_W-1:0] hi;
    logic signed [MAC_MAX_W-1:0] lo;
    conv_res_t                   res;
    hi          = (64'sd1 <<< (dout_w - 1)) - 64'sd1;
    lo          = -(64'sd1 <<< (dout_w - 1));
    res.val     = acc;
    res.clamped = 1'b0;
    if (mode == MAC_SAT) begin
      if (acc > hi) begin
        res.val     = hi;
        res.clamped = 1'b1;
      end else if (acc < lo) begin
        res.val     = lo;
        res.clamped = 1'b1;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/pe_mac_if.sv
// Operand-in / result-out bundle between the PE operand FIFOs, the MAC and
// the PE result writer.
interface pe_mac_if #(
  parameter int unsigned DIN0_WIDTH = 16,
  parameter int unsigned DIN1_WIDTH = 16,
  parameter int unsigned DOUT_WIDTH = 16
);
  logic                  in_valid;
  logic [DIN0_WIDTH-1:0] din0;
  logic [DIN1_WIDTH-1:0] din1;
  logic                  first;
  logic                  last;
  logic                  out_valid;
  logic [DOUT_WIDTH-1:0] dout;
  logic                  ovf;

  // Operand producer / result consumer side.
  modport master (
    output in_valid, din0, din1, first, last,
    input  out_valid, dout, ovf
  );

  // MAC side.
  modport slave (
    input  in_valid, din0, din1, first, last,
    output out_valid, dout, ovf
  );
endinterface

// File: rtl/pe_mul_pipe.sv
// Signed multiplier followed by a NUM_STAGE-deep register chain; the control
// token rides alongside the product. Every register freezes while ce=0.
module pe_mul_pipe
  import pe_mac_pkg::*;
#(
  parameter int unsigned DIN0_WIDTH = 16,
  parameter int unsigned DIN1_WIDTH = 16,
  parameter int unsigned NUM_STAGE  = 2
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   ce,
  input  stage_tok_t                             in_tok,
  input  logic signed [DIN0_WIDTH-1:0]           din0,
  input  logic signed [DIN1_WIDTH-1:0]           din1,
  output stage_tok_t                             out_tok,
  output logic signed [DIN0_WIDTH+DIN1_WIDTH-1:0] prod
);

  localparam int unsigned PROD_W = DIN0_WIDTH + DIN1_WIDTH;

  logic signed [PROD_W-1:0] prod_q [NUM_STAGE];
  logic signed [PROD_W-1:0] prod_d [NUM_STAGE];
  stage_tok_t               tok_q  [NUM_STAGE];
  stage_tok_t               tok_d  [NUM_STAGE];

  // Stage 0 takes the fresh product; later stages shift the previous one.
  always_comb begin
    prod_d[0] = PROD_W'(din0) * PROD_W'(din1);
    tok_d[0]  = in_tok;
    for (int unsigned i = 1; i < NUM_STAGE; i++) begin
      prod_d[i] = prod_q[i-1];
      tok_d[i]  = tok_q[i-1];
    end
  end

  // Pipeline registers, cleared on reset, held while ce is low.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_STAGE; i++) begin
        prod_q[i] <= '0;
        tok_q[i]  <= '0;
      end
    end else if (ce) begin
      for (int unsigned i = 0; i < NUM_STAGE; i++) begin
        prod_q[i] <= prod_d[i];
        tok_q[i]  <= tok_d[i];
      end
    end
  end

  assign prod    = prod_q[NUM_STAGE-1];
  assign out_tok = tok_q[NUM_STAGE-1];

endmodule

// File: rtl/pe_mac_pipe.sv
// Pipelined signed multiply-accumulate with first/last reduction framing,
// sticky accumulator-overflow tracking and wrap/saturate output conversion.
module pe_mac_pipe
  import pe_mac_pkg::*;
#(
  parameter int unsigned DIN0_WIDTH = 16,
  parameter int unsigned DIN1_WIDTH = 16,
  parameter int unsigned ACC_WIDTH  = 40,
  parameter int unsigned DOUT_WIDTH = 16,
  parameter int unsigned NUM_STAGE  = 2,
  parameter int unsigned SAT_MODE   = 0
) (
  input  logic     ap_clk,
  input  logic     ap_rst,
  input  logic     ce,
  pe_mac_if.slave  bus
);

  localparam int unsigned PROD_W = DIN0_WIDTH + DIN1_WIDTH;
  localparam sat_mode_e   MODE   = (SAT_MODE == 1) ? MAC_SAT : MAC_WRAP;

  stage_tok_t               in_tok;
  stage_tok_t               tail_tok;
  logic signed [PROD_W-1:0] tail_prod;

  assign in_tok.valid = bus.in_valid;
  assign in_tok.first = bus.first;
  assign in_tok.last  = bus.last;

  pe_mul_pipe #(
    .DIN0_WIDTH (DIN0_WIDTH),
    .DIN1_WIDTH (DIN1_WIDTH),
    .NUM_STAGE  (NUM_STAGE)
  ) u_mul (
    .clk     (ap_clk),
    .rst     (ap_rst),
    .ce      (ce),
    .in_tok  (in_tok),
    .din0    (bus.din0),
    .din1    (bus.din1),
    .out_tok (tail_tok),
    .prod    (tail_prod)
  );

  logic signed [ACC_WIDTH-1:0]  acc_q, acc_d;
  logic                         ovf_acc_q, ovf_acc_d;
  logic                         out_valid_q, out_valid_d;
  logic [DOUT_WIDTH-1:0]        dout_q, dout_d;
  logic                         ovf_q, ovf_d;

  logic signed [ACC_WIDTH-1:0]  p_ext;
  logic signed [ACC_WIDTH-1:0]  sum;
  logic signed [ACC_WIDTH-1:0]  acc_new;
  logic                         add_ovf;
  logic                         ovf_acc_new;
  conv_res_t                    conv;
  logic                         conv_unused;

  // Accumulate the product leaving the pipe and prepare the output register.
  always_comb begin
    p_ext       = ACC_WIDTH'(tail_prod);
    sum         = acc_q + p_ext;
    add_ovf     = (acc_q[ACC_WIDTH-1] == p_ext[ACC_WIDTH-1]) &&
                  (sum[ACC_WIDTH-1] != acc_q[ACC_WIDTH-1]);
    acc_new     = acc_q;
    ovf_acc_new = ovf_acc_q;
    if (tail_tok.valid) begin
      if (tail_tok.first) begin
        acc_new     = p_ext;
        ovf_acc_new = 1'b0;
      end else begin
        acc_new     = sum;
        ovf_acc_new = ovf_acc_q | add_ovf;
      end
    end
    conv        = mac_convert(MAC_MAX_W'(acc_new), DOUT_WIDTH, MODE);
    conv_unused = ^conv.val;
    acc_d       = acc_new;
    ovf_acc_d   = ovf_acc_new;
    out_valid_d = tail_tok.valid & tail_tok.last;
    dout_d      = out_valid_d ? conv.val[DOUT_WIDTH-1:0] : dout_q;
    ovf_d       = out_valid_d ? (ovf_acc_new | conv.clamped) : ovf_q;
  end

  // Accumulator and output registers; ce=0 holds everything, so a pending
  // out_valid pulse stretches across stall cycles.
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      acc_q       <= '0;
      ovf_acc_q   <= 1'b0;
      out_valid_q <= 1'b0;
      dout_q      <= '0;
      ovf_q       <= 1'b0;
    end else if (ce) begin
      acc_q       <= acc_d;
      ovf_acc_q   <= ovf_acc_d;
      out_valid_q <= out_valid_d;
      dout_q      <= dout_d;
      ovf_q       <= ovf_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.dout      = dout_q;
  assign bus.ovf       = ovf_q;

endmodule
